// File: rtl/if_stage_pkg.sv
// Shared pipeline types and constants for the IF and ID stages.
// Holds the IF/ID bundle layout and the NOP encoding.
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC priority mux: branch, then jump, then hold, then PC+4.
// Redirect targets are word-aligned by clearing bits [1:0].
module if_next_pc
  import if_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            hold_i,
  input  logic            br_i,
  input  logic [XLEN-1:0] br_tgt_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_tgt_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic            redirect_o
);

  // Select next PC; redirects override the hold request.
  always_comb begin
    pc_d_o     = pc_i + 32'd4;
    redirect_o = 1'b0;
    priority case (1'b1)
      br_i: begin
        pc_d_o     = br_tgt_i & ~ALIGN_MASK;
        redirect_o = 1'b1;
      end
      jmp_i: begin
        pc_d_o     = jmp_tgt_i & ~ALIGN_MASK;
        redirect_o = 1'b1;
      end
      hold_i: begin
        pc_d_o = pc_i;
      end
      default: begin
        pc_d_o = pc_i + 32'd4;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, redirect flush.
// Optional perf counters built when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCwrite,
  input  logic             IFIDwrite,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            redirect;
  ifid_t           ifid_q;
  ifid_t           ifid_d;

  if_next_pc u_next_pc (
    .pc_i      (pc_q),
    .hold_i    (PCwrite),
    .br_i      (ex_branch_taken),
    .br_tgt_i  (ex_branch_target),
    .jmp_i     (id_jump),
    .jmp_tgt_i (id_jump_target),
    .pc_d_o    (pc_d),
    .redirect_o(redirect)
  );

  // PC register; hold and redirect are already folded into pc_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // IF/ID next state: flush on redirect, else hold or load.
  always_comb begin
    ifid_d = ifid_q;
    if (redirect) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.pc4   = '0;
      ifid_d.valid = 1'b0;
    end else if (!IFIDwrite) begin
      ifid_d.instr = imem_rdata;
      ifid_d.pc4   = pc_q + 32'd4;
      ifid_d.valid = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc4   <= '0;
      ifid_q.valid <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating stall and redirect counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (PCwrite && !redirect && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (redirect && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: random and directed fetch traffic.
// Expected state comes from an abstract fetch model in the bench.
module tb_if_stage;

  localparam int CNT_W = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [31:0]      pc4;
    logic             valid;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pcw = 1'b0;
  logic ifw = 1'b0;
  logic br = 1'b0;
  logic [31:0] bt = '0;
  logic jp = 1'b0;
  logic [31:0] jt = '0;
  logic [31:0] rdata;
  logic [31:0] iaddr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic valid;
  logic [CNT_W-1:0] scnt;
  logic [CNT_W-1:0] fcnt;

  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t m;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rdata = mem(iaddr);

  if_stage #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PCwrite         (pcw),
    .IFIDwrite       (ifw),
    .ex_branch_taken (br),
    .ex_branch_target(bt),
    .id_jump         (jp),
    .id_jump_target  (jt),
    .imem_rdata      (rdata),
    .imem_addr       (iaddr),
    .pc              (pc),
    .ifid_instr      (instr),
    .ifid_pc4        (pc4),
    .ifid_valid      (valid),
    .stall_cnt       (scnt),
    .flush_cnt       (fcnt)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  task automatic model_reset();
    m.pc = RST_PC;
    m.instr = '0;
    m.pc4 = '0;
    m.valid = 1'b0;
    m.scnt = '0;
    m.fcnt = '0;
  endtask

  // Called at a negedge: apply inputs, advance model, queue the
  // state expected after the next rising edge.
  task automatic drive(input logic p, input logic f, input logic b,
                       input logic [31:0] btg, input logic j,
                       input logic [31:0] jtg);
    logic [31:0] tgt;
    pcw = p; ifw = f; br = b; bt = btg; jp = j; jt = jtg;
    tgt = b ? btg : jtg;
    if (b || j) begin
      m.instr = '0; m.pc4 = '0; m.valid = 1'b0;
    end else if (!f) begin
      m.instr = mem(m.pc); m.pc4 = m.pc + 32'd4; m.valid = 1'b1;
    end
`ifdef IF_PERF_CNT_EN
    if (b || j) m.fcnt = sat_inc(m.fcnt);
    else if (p) m.scnt = sat_inc(m.scnt);
`endif
    if (b || j) m.pc = {tgt[31:2], 2'b00};
    else if (!p) m.pc = m.pc + 32'd4;
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0, '0);
  endtask

  task automatic check_reset(input string nm);
    n_vec++;
    if (pc !== RST_PC || iaddr !== RST_PC || instr !== 32'h0 ||
        pc4 !== 32'h0 || valid !== 1'b0 || scnt !== '0 || fcnt !== '0) begin
      n_err++;
      $display("FAIL %s: pc=%h instr=%h pc4=%h v=%b s=%0d f=%0d want reset values",
               nm, pc, instr, pc4, valid, scnt, fcnt);
    end
  endtask

  // Monitor: after every rising edge compare DUT to the queued state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (pc !== e.pc || iaddr !== e.pc || instr !== e.instr ||
            pc4 !== e.pc4 || valid !== e.valid ||
            scnt !== e.scnt || fcnt !== e.fcnt) begin
          n_err++;
          $display("FAIL cyc@%0t: pc=%h/%h instr=%h/%h pc4=%h/%h v=%b/%b s=%0d/%0d f=%0d/%0d (got/want)",
                   $time, pc, e.pc, instr, e.instr, pc4, e.pc4,
                   valid, e.valid, scnt, e.scnt, fcnt, e.fcnt);
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    #3;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // sequential fetch: pc4 = 4, 8, 12, 16
    run(4);
    // two-cycle full stall at pc=0x10, then resume
    drive(1, 1, 0, '0, 0, '0);
    drive(1, 1, 0, '0, 0, '0);
    run(2);
    // branch while PC held
    drive(1, 0, 1, 32'h40, 0, '0);
    run(2);
    // PC held, IF/ID reloading
    drive(1, 0, 0, '0, 0, '0);
    drive(1, 0, 0, '0, 0, '0);
    // simultaneous branch and jump: branch wins
    drive(0, 0, 1, 32'h40, 1, 32'h80);
    run(1);
    // jump alone, misaligned target 0x43
    drive(0, 1, 0, '0, 1, 32'h43);
    run(1);
    // wrap from FFFF_FFF8 through FFFF_FFFC to 0
    drive(0, 0, 1, 32'hFFFF_FFF9, 0, '0);
    run(3);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            r == 0 || r == 1, $urandom, r == 1 || r == 2, $urandom);
    end
    // asynchronous reset mid-cycle during a redirect
    br = 1'b1; bt = 32'h200; jp = 1'b1; jt = 32'h300;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    run(3);
    drive(1, 1, 0, '0, 1, 32'h1000);
    run(2);
    @(posedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: queue=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and consumes its `PCwrite` / `IFIDwrite` stall requests. It also accepts branch redirects from EX and jump redirects from ID.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `CNT_W`, default 16: width of the performance counters (only used with `IF_PERF_CNT_EN`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCwrite` in 1: hold request from the hazard unit. 1 = freeze PC. The polarity is inverted relative to the name, and this is intentional.
- `IFIDwrite` in 1: hold request from the hazard unit. 1 = freeze the IF/ID register (same polarity as `PCwrite`).
- `ex_branch_taken` in 1: a branch resolved taken in EX this cycle.
- `ex_branch_target` in 32: branch target address.
- `id_jump` in 1: a jump was decoded in ID this cycle.
- `id_jump_target` in 32: jump target address.
- `imem_rdata` in 32: instruction word; combinational read of `imem_addr`.
- `imem_addr` out 32: equals `pc`.
- `pc` out 32: current fetch PC.
- `ifid_instr` out 32: registered instruction.
- `ifid_pc4` out 32: registered PC+4 of that instruction.
- `ifid_valid` out 1: 1 = `ifid_instr` is a real instruction; 0 = bubble.
- `stall_cnt` out CNT_W: number of cycles with `PCwrite`=1 (only with `IF_PERF_CNT_EN`).
- `flush_cnt` out CNT_W: number of redirects taken (only with `IF_PERF_CNT_EN`).

## Operation
- Next-PC priority, highest first:
  - `ex_branch_taken` → `ex_branch_target`
  - `id_jump` → `id_jump_target`
  - `PCwrite`=1 → hold `pc`
  - otherwise → `pc`+4
- Redirects override `PCwrite`. The hazard unit holds the PC while a branch sits in EX, and the target must not be lost.
- Targets are loaded with bits [1:0] forced to 0. PC+4 wraps modulo 2^32 (FFFF_FFFC → 0000_0000).
- IF/ID update priority, highest first:
  - any redirect (`ex_branch_taken` or `id_jump`) → bubble: `ifid_instr`=0 (sll $0 NOP), `ifid_pc4`=0, `ifid_valid`=0.
  - `IFIDwrite`=1 → hold all three fields.
  - otherwise → load `imem_rdata`, `pc`+4, and `ifid_valid`=1.
- Simultaneous `ex_branch_taken` and `id_jump`: the branch wins. The jump in ID is younger and is discarded by the flush.
- `PCwrite`=1 with `IFIDwrite`=0 is legal. IF/ID reloads the same fetched word each cycle.
- Reset (asynchronous, at any point including mid-redirect):
  - `pc`=RESET_PC
  - `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0
  - counters = 0
- The first fetch occurs in the first clock after `rst_n` rises.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The instruction at `pc` in cycle n appears on `ifid_instr` in cycle n+1.
- A redirect asserted in cycle n gives:
  - `pc`=target in cycle n+1.
  - a bubble in IF/ID in cycle n+1.
  - the target instruction in IF/ID in cycle n+2.
- Redirect penalty, counted at the IF/ID register: 1 bubble for an `id_jump`, 1 bubble for `ex_branch_taken`. Younger instructions already in ID/EX are squashed by control logic elsewhere, not here.
- Hold inputs take effect at the same edge they are sampled. There is no registering of `PCwrite` or `IFIDwrite`.
- All outputs are registered except `imem_addr`, which is a wire copy of `pc`.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with `PCwrite`=1 and no redirect.
  - `flush_cnt` increments on each redirect cycle.
  - Both counters saturate at all-ones and clear only on reset.
- `IF_PERF_CNT_EN` undefined:
  - Counter registers are not built.
  - `stall_cnt` and `flush_cnt` are tied to 0.
  - Ports remain present.

## Structure
- Shared pipeline package holds:
  - `NOP_INSTR` = 32'h0000_0000
  - the instruction/address width constant (32)
  - a packed `ifid_t` struct {instr, pc4, valid} shared with the ID stage
- One sub-module: `if_next_pc`. It is the combinational next-PC priority mux and alignment logic.
- PC register, IF/ID register and counters stay in `if_stage`.

## Test plan
- Reset release with RESET_PC=0, `imem_rdata`=mem[pc>>2] → `ifid_pc4` = 4, 8, 12 on successive cycles, with `ifid_valid`=1 from cycle 1.
- `PCwrite`=`IFIDwrite`=1 for 2 cycles at pc=0x10 → `pc` stays 0x10, and IF/ID holds the instruction from 0x0C; fetch resumes at 0x14 afterwards. With the macro, `stall_cnt`=2.
- `ex_branch_taken`=1 with target 0x40 while `PCwrite`=1 → next cycle `pc`=0x40 and `ifid_valid`=0; the following cycle IF/ID holds mem[0x40] with `ifid_pc4`=0x44.
- `id_jump` (target 0x80) and `ex_branch_taken` (target 0x40) in the same cycle → `pc`=0x40, and `flush_cnt` increments by exactly 1.
- Target 0x43 → `pc`=0x40. `pc`=FFFF_FFFC advancing → `pc`=0000_0000.
- `rst_n` pulsed low asynchronously mid-cycle during a redirect → outputs return to reset values immediately, without waiting for a clock edge.
